yonga_lz4_encoder: RTL and testbench

YONGA_LZ4_ENCODER -- requirements
Module: yonga_lz4_encoder

---
 rtl/yonga_lz4_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_yonga_lz4_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/yonga_lz4_encoder.sv
// yonga_lz4_encoder: buffers one block of up to 128 raw bytes, then emits it
// as a raw LZ4 block (no frame header), one byte per cycle into a FIFO.
// Optional macro YONGA_LZ4_ENC_MATCH_EN enables the offset-1 (run) match
// search; without it every block is a single literal-only sequence.
module yonga_lz4_encoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_lz4_compress_enable,
  input  logic       i_lz4_compress_start,
  input  logic       i_raw_data_valid,
  input  logic [7:0] i_raw_data,
  input  logic       i_raw_last,
  output logic       o_raw_data_ready,
  input  logic       i_compress_fifo_full,
  output logic       o_compress_data_write,
  output logic [7:0] o_compress_data,
  output logic       o_idle
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_SCAN   = 4'd2;
  localparam logic [3:0] S_TOKEN  = 4'd3;
  localparam logic [3:0] S_LITEXT = 4'd4;
  localparam logic [3:0] S_LIT    = 4'd5;
  localparam logic [3:0] S_OFFLO  = 4'd6;
  localparam logic [3:0] S_OFFHI  = 4'd7;
  localparam logic [3:0] S_MATEXT = 4'd8;

  logic [3:0] r_state;
  logic [7:0] r_len;       // bytes stored in the block buffer
  logic [7:0] r_p;         // current position; doubles as literal read pointer
  logic [7:0] r_litlen;    // literal length of the sequence being emitted
  logic [7:0] r_lit_left;  // literals still to emit
  logic       r_last;      // sequence being emitted is the final one
  logic [7:0] r_buf [0:127];

  logic       w_emit;
  logic       w_fire;
  logic [3:0] w_lit_nib;
  logic [3:0] w_mat_nib;
  logic [7:0] w_byte;

`ifdef YONGA_LZ4_ENC_MATCH_EN
  logic [7:0] r_q;         // candidate match start
  logic [7:0] r_L;         // match length being grown
  logic       r_ext;       // 0: searching for q, 1: extending L
  logic [6:0] w_q7;
  logic [7:0] w_ref;
  logic       w_hit;
  logic       w_q_past;
  logic [7:0] w_ext_pos;
  logic       w_ext_ok;
  logic [7:0] w_mlen;

  // Offset-1 match: four bytes at q equal the byte just before q.
  always_comb begin
    w_q7      = r_q[6:0];
    w_ref     = r_buf[w_q7 - 7'd1];
    w_hit     = (r_buf[w_q7] == w_ref) && (r_buf[w_q7 + 7'd1] == w_ref) &&
                (r_buf[w_q7 + 7'd2] == w_ref) && (r_buf[w_q7 + 7'd3] == w_ref);
    // a match may not start within the last 12 bytes
    w_q_past  = ({1'b0, r_q} + 9'd12) > {1'b0, r_len};
    // the match must leave at least 5 trailing literals
    w_ext_pos = r_q + r_L;
    w_ext_ok  = (({1'b0, w_ext_pos} + 9'd6) <= {1'b0, r_len}) &&
                (r_buf[w_ext_pos[6:0]] == w_ref);
    w_mlen    = r_L - 8'd4;
  end
`endif

  // Output byte for the current emission state; held while the FIFO is full.
  always_comb begin
    w_emit    = (r_state >= S_TOKEN) && (r_state <= S_MATEXT);
    w_fire    = w_emit && !i_compress_fifo_full;
    w_lit_nib = (r_litlen >= 8'd15) ? 4'hF : r_litlen[3:0];
`ifdef YONGA_LZ4_ENC_MATCH_EN
    w_mat_nib = r_last ? 4'h0 : ((w_mlen >= 8'd15) ? 4'hF : w_mlen[3:0]);
`else
    w_mat_nib = 4'h0;
`endif
    w_byte = 8'h00;
    case (r_state)
      S_TOKEN:  w_byte = {w_lit_nib, w_mat_nib};
      S_LITEXT: w_byte = r_litlen - 8'd15;
      S_LIT:    w_byte = r_buf[r_p[6:0]];
`ifdef YONGA_LZ4_ENC_MATCH_EN
      S_OFFLO:  w_byte = 8'h01;
      S_OFFHI:  w_byte = 8'h00;
      S_MATEXT: w_byte = w_mlen - 8'd15;
`endif
      default:  w_byte = 8'h00;
    endcase
  end

  assign o_compress_data       = w_byte;
  assign o_compress_data_write = w_fire;
  assign o_raw_data_ready      = (r_state == S_LOAD);
  assign o_idle                = (r_state == S_IDLE);

  // Block buffer: raw bytes land at position r_len while loading.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && i_raw_data_valid)
      r_buf[r_len[6:0]] <= i_raw_data;
  end

  // Main control FSM: load, search, then emit each sequence byte by byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= 8'd0;
      r_p        <= 8'd0;
      r_litlen   <= 8'd0;
      r_lit_left <= 8'd0;
      r_last     <= 1'b0;
`ifdef YONGA_LZ4_ENC_MATCH_EN
      r_q        <= 8'd0;
      r_L        <= 8'd0;
      r_ext      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_lz4_compress_start && i_lz4_compress_enable) begin
            r_state <= S_LOAD;
            r_len   <= 8'd0;
            r_p     <= 8'd0;
          end
        end
        S_LOAD: begin
          if (i_raw_data_valid) begin
            r_len <= r_len + 8'd1;
            if (i_raw_last || r_len == 8'd127) begin
              r_state <= S_SCAN;
`ifdef YONGA_LZ4_ENC_MATCH_EN
              r_q     <= 8'd1;
              r_ext   <= 1'b0;
`endif
            end
          end
        end
        S_SCAN: begin
`ifdef YONGA_LZ4_ENC_MATCH_EN
          if (!r_ext) begin
            if (w_q_past) begin
              r_litlen   <= r_len - r_p;
              r_lit_left <= r_len - r_p;
              r_last     <= 1'b1;
              r_state    <= S_TOKEN;
            end else if (w_hit) begin
              r_ext <= 1'b1;
              r_L   <= 8'd4;
            end else begin
              r_q <= r_q + 8'd1;
            end
          end else if (w_ext_ok) begin
            r_L <= r_L + 8'd1;
          end else begin
            r_litlen   <= r_q - r_p;
            r_lit_left <= r_q - r_p;
            r_last     <= 1'b0;
            r_ext      <= 1'b0;
            r_state    <= S_TOKEN;
          end
`else
          r_litlen   <= r_len - r_p;
          r_lit_left <= r_len - r_p;
          r_last     <= 1'b1;
          r_state    <= S_TOKEN;
`endif
        end
        S_TOKEN: begin
          if (w_fire) begin
            if (r_litlen >= 8'd15)     r_state <= S_LITEXT;
            else if (r_litlen != 8'd0) r_state <= S_LIT;
            else if (r_last)           r_state <= S_IDLE;
            else                       r_state <= S_OFFLO;
          end
        end
        S_LITEXT: begin
          if (w_fire) r_state <= S_LIT;
        end
        S_LIT: begin
          if (w_fire) begin
            r_p        <= r_p + 8'd1;
            r_lit_left <= r_lit_left - 8'd1;
            if (r_lit_left == 8'd1) r_state <= r_last ? S_IDLE : S_OFFLO;
          end
        end
`ifdef YONGA_LZ4_ENC_MATCH_EN
        S_OFFLO: begin
          if (w_fire) r_state <= S_OFFHI;
        end
        S_OFFHI: begin
          if (w_fire) begin
            if (w_mlen >= 8'd15) begin
              r_state <= S_MATEXT;
            end else begin
              r_state <= S_SCAN;
              r_p     <= r_p + r_L;
              r_q     <= r_p + r_L;
            end
          end
        end
        S_MATEXT: begin
          if (w_fire) begin
            r_state <= S_SCAN;
            r_p     <= r_p + r_L;
            r_q     <= r_p + r_L;
          end
        end
`else
        // match-only states are unreachable without the search
        S_OFFLO, S_OFFHI, S_MATEXT: r_state <= S_IDLE;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yonga_lz4_encoder.sv
// Directed bench for yonga_lz4_encoder; expectations follow the
// YONGA_LZ4_ENC_MATCH_EN setting the bench is compiled with.
module tb_yonga_lz4_encoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, start = 1'b0, valid = 1'b0, last = 1'b0, full = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, wr, idle;
  logic [7:0] odata;

  int total = 0;
  int bad = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit no_last = 1'b0;

  yonga_lz4_encoder dut (
    .clk(clk), .rst(rst),
    .i_lz4_compress_enable(en), .i_lz4_compress_start(start),
    .i_raw_data_valid(valid), .i_raw_data(data), .i_raw_last(last),
    .o_raw_data_ready(ready), .i_compress_fifo_full(full),
    .o_compress_data_write(wr), .o_compress_data(odata), .o_idle(idle)
  );

  always #5 clk = ~clk;

  // capture every byte written to the FIFO
  always @(negedge clk) if (wr) rx_q.push_back(odata);

  task automatic load_block;
    int n;
    @(posedge clk); #1; start = 1'b1; en = 1'b1;
    @(posedge clk); #1; start = 1'b0; en = 1'b0;
    for (int i = 0; i < tx_q.size(); i++) begin
      valid = 1'b1; data = tx_q[i]; last = !no_last && (i == tx_q.size() - 1);
      n = 0;
      @(negedge clk);
      while (!ready && n < 50) begin @(negedge clk); n++; end
      if (!ready) begin
        total++; bad++; $display("FAIL load_ready byte%0d got=0 want=1", i);
      end
      @(posedge clk); #1;
    end
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    @(negedge clk);
    while (!idle && n < 3000) begin @(negedge clk); n++; end
    if (!idle) begin total++; bad++; $display("FAIL idle_timeout got=0 want=1"); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk); #1;
    total++; if (idle !== 1'b1)  begin bad++; $display("FAIL rst_idle got=%b want=1", idle); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
    total++; if (wr !== 1'b0)    begin bad++; $display("FAIL rst_write got=%b want=0", wr); end
    total++; if (odata !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", odata); end
    rst = 1'b0;
  endtask

  task automatic test_start_no_enable;
    @(posedge clk); #1; start = 1'b1; en = 1'b0;
    @(posedge clk); #1; start = 1'b0; en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (idle !== 1'b1)  begin bad++; $display("FAIL noen_idle got=%b want=1", idle); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL noen_ready got=%b want=0", ready); end
    end
  endtask

  task automatic test_abcde;
    rx_q.delete(); tx_q.delete(); exp_q.delete(); no_last = 1'b0;
    exp_q.push_back(8'h50);
    for (int i = 0; i < 5; i++) begin tx_q.push_back(8'h41 + 8'(i)); exp_q.push_back(8'h41 + 8'(i)); end
    load_block(); wait_idle();
    @(negedge clk);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL abcde_idle got=%b want=1", idle); end
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL abcde_len got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size()) begin bad++; $display("FAIL abcde_byte%0d got=none want=%h", i, exp_q[i]); end
      else if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL abcde_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic build_run20;
    rx_q.delete(); tx_q.delete(); exp_q.delete(); no_last = 1'b0;
    for (int i = 0; i < 20; i++) tx_q.push_back(8'h41);
`ifdef YONGA_LZ4_ENC_MATCH_EN
    exp_q = '{8'h1A, 8'h41, 8'h01, 8'h00, 8'h50, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
`else
    exp_q = '{8'hF0, 8'h05};
    for (int i = 0; i < 20; i++) exp_q.push_back(8'h41);
`endif
  endtask

  task automatic test_run20;
    build_run20();
    load_block(); wait_idle();
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL run20_len got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size()) begin bad++; $display("FAIL run20_byte%0d got=none want=%h", i, exp_q[i]); end
      else if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL run20_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_incr16;
    rx_q.delete(); tx_q.delete(); exp_q.delete(); no_last = 1'b0;
    exp_q = '{8'hF0, 8'h01};
    for (int i = 0; i < 16; i++) begin tx_q.push_back(8'(i)); exp_q.push_back(8'(i)); end
    load_block(); wait_idle();
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL incr16_len got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size()) begin bad++; $display("FAIL incr16_byte%0d got=none want=%h", i, exp_q[i]); end
      else if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL incr16_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall;
    logic [7:0] stall_exp;
`ifdef YONGA_LZ4_ENC_MATCH_EN
    stall_exp = 8'h00;   // offset high byte waits
`else
    stall_exp = 8'h41;   // second literal waits
`endif
    build_run20();
    fork
      begin load_block(); wait_idle(); end
      begin
        int w, n;
        w = 0; n = 0;
        while (w < 3 && n < 500) begin @(negedge clk); if (wr) w++; n++; end
        if (w < 3) begin total++; bad++; $display("FAIL stall_wait got=%0d want=3", w); end
        @(posedge clk); #1; full = 1'b1;
        repeat (10) begin
          @(negedge clk);
          total++; if (wr !== 1'b0) begin bad++; $display("FAIL stall_write got=%b want=0", wr); end
          total++; if (odata !== stall_exp) begin bad++; $display("FAIL stall_data got=%h want=%h", odata, stall_exp); end
        end
        @(posedge clk); #1; full = 1'b0;
      end
    join
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL stall_len got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size()) begin bad++; $display("FAIL stall_byte%0d got=none want=%h", i, exp_q[i]); end
      else if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midload;
    rx_q.delete(); tx_q.delete(); no_last = 1'b1;
    tx_q = '{8'h11, 8'h22, 8'h33};
    load_block();
    rst = 1'b1; #1;
    total++; if (idle !== 1'b1)  begin bad++; $display("FAIL midrst_idle got=%b want=1", idle); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", ready); end
    total++; if (wr !== 1'b0)    begin bad++; $display("FAIL midrst_write got=%b want=0", wr); end
    total++; if (odata !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", odata); end
    @(posedge clk); #1; rst = 1'b0;
    no_last = 1'b0;
    test_abcde();
  endtask

  task automatic test_full_128;
    rx_q.delete(); tx_q.delete(); exp_q.delete(); no_last = 1'b1;
    exp_q = '{8'hF0, 8'h71};
    for (int i = 0; i < 128; i++) begin tx_q.push_back(8'(i)); exp_q.push_back(8'(i)); end
    load_block();
    @(negedge clk);
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL full128_ready got=%b want=0", ready); end
    wait_idle();
    no_last = 1'b0;
    total++; if (rx_q.size() !== exp_q.size()) begin bad++; $display("FAIL full128_len got=%0d want=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= rx_q.size()) begin bad++; $display("FAIL full128_byte%0d got=none want=%h", i, exp_q[i]); end
      else if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL full128_byte%0d got=%h want=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_start_no_enable();
    test_abcde();
    test_run20();
    test_incr16();
    test_stall();
    test_reset_midload();
    test_full_128();
    test_abcde();   // back-to-back blocks after a max-size block
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
